golden_nonce_reporter: RTL and testbench
========================================

GOLDEN_NONCE_REPORTER -- requirements
Module: golden_nonce_reporter

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2: the nonce FIFO holds 2^DEPTH_LOG2 entries (legal values 1..4).
REQ-002 SHALL have parameter HEADER, default 8'hA5: the sync byte sent at the start of every frame.
REQ-003 SHALL have port hash_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port nonce_valid, input, 1 bit: a one-cycle pulse marking a new golden nonce.
REQ-006 SHALL have port nonce_in, input, 32 bits: the golden nonce, sampled when nonce_valid=1.
REQ-007 SHALL have port tx_data, output, 8 bits: the byte offered to the downstream UART transmitter.
REQ-008 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-009 SHALL have port tx_ready, input, 1 bit: the transmitter accepts the byte; a transfer occurs on a cycle with tx_valid=1 and tx_ready=1.
REQ-010 SHALL have port fifo_level, output, DEPTH_LOG2+1 bits: the number of queued nonces, not counting the frame in flight.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when any nonce has been dropped.
REQ-012 SHALL have port drop_count, output, 8 bits: saturating count of dropped nonces.

Function
REQ-013 SHALL push nonce_in into the FIFO on a cycle with nonce_valid=1 when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 SHALL, on nonce_valid=1 with the FIFO full and no same-cycle pop, drop the incoming nonce, keep the queue contents unchanged, set overflow=1 and increment drop_count, saturating at 8'hFF.
REQ-015 SHALL implement an FSM with states IDLE and SEND.
REQ-016 SHALL, in IDLE with fifo_level>0, pop the head entry into a 32-bit frame register, set the byte index to 0 and enter SEND on the next cycle; the pop counts as a pop for REQ-013.
REQ-017 SHALL, in SEND, send a 5-byte frame in this order: HEADER, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0].
REQ-018 SHALL advance the byte index only on a transfer cycle.
REQ-019 SHALL drive tx_valid=1 for the whole of SEND and tx_valid=0 in IDLE.
REQ-020 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-021 SHALL, on the transfer of byte 4: pop the next entry and stay in SEND with byte index 0 if fifo_level>0 (back-to-back frames, no idle cycle); otherwise go to IDLE.
REQ-022 SHALL make the latency from nonce_valid with an empty FIFO in IDLE to tx_valid=1 carrying HEADER exactly 2 cycles.
REQ-023 SHALL leave fifo_level unchanged on a simultaneous push and pop; SHALL wrap the read and write pointers modulo 2^DEPTH_LOG2.
REQ-024 SHALL NOT let tx_ready affect the FIFO outside a frame-boundary pop.
REQ-025 SHALL emit the FIFO contents in arrival order.
REQ-026 SHALL ignore nonce_in when nonce_valid=0.

Reset
REQ-027 SHALL, while reset=1 on a clock edge, set state=IDLE, tx_valid=0, tx_data=8'h00, fifo_level=0, overflow=0, drop_count=0, and both pointers and the byte index to 0.
REQ-028 SHALL, on reset asserted mid-frame, abandon the frame; after deassertion no partial bytes are sent and the FIFO is empty.
REQ-029 SHALL ignore nonce_valid on any cycle with reset=1.

Verification
REQ-030 Single nonce 32'h1D2C3B4A, tx_ready tied 1 -> bytes A5,1D,2C,3B,4A on 5 consecutive cycles, first byte 2 cycles after the pulse; then tx_valid=0 and fifo_level=0.
REQ-031 Backpressure: tx_ready=0 for 10 cycles after the frame starts -> tx_data holds A5 with tx_valid=1 throughout; the frame completes unchanged once tx_ready=1.
REQ-032 DEPTH_LOG2=2, tx_ready=0, six pulses with nonces 1..6 -> nonce 1 in flight, nonces 2..5 queued (fifo_level=4), nonce 6 dropped (overflow=1, drop_count=1); with tx_ready=1 the output is frames 1,2,3,4,5 back-to-back, 25 bytes.
REQ-033 FIFO full with a pulse on the same cycle as the byte-4 transfer -> the nonce is accepted, fifo_level stays 4, drop_count unchanged.
REQ-034 Reset pulsed on byte 2 of a frame with 3 entries queued -> next cycle tx_valid=0, fifo_level=0, overflow=0; a new nonce 32'hFFFFFFFF then yields A5,FF,FF,FF,FF.
REQ-035 300 drops with tx_ready=0 -> drop_count saturates at 8'hFF and overflow=1.

Source files
------------

// File: rtl/golden_nonce_reporter.sv
// ---------------------------------------------------------------------------
// golden_nonce_reporter
//
// Queues golden nonces from the hashing core and streams each one to a UART
// transmitter as a 5-byte frame: HEADER, nonce[31:24], nonce[23:16],
// nonce[15:8], nonce[7:0]. Frames are sent back-to-back while nonces are
// queued. When the queue is full, incoming nonces are dropped and counted.
//
// Parameters
//   DEPTH_LOG2  queue holds 2**DEPTH_LOG2 nonces (1..4)
//   HEADER      sync byte leading every frame
//
// Ports
//   hash_clk     single rising-edge clock
//   reset        synchronous, active-high reset
//   nonce_valid  one-cycle pulse: nonce_in carries a new golden nonce
//   nonce_in     32-bit golden nonce
//   tx_data      byte offered to the UART transmitter (registered)
//   tx_valid     tx_data is valid (registered, high for the whole frame)
//   tx_ready     transmitter accepts tx_data this cycle
//   fifo_level   queued nonces, excluding the frame in flight
//   overflow     sticky: at least one nonce was dropped
//   drop_count   saturating count of dropped nonces
// ---------------------------------------------------------------------------
module golden_nonce_reporter #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                  hash_clk,
    input  logic                  reset,
    input  logic                  nonce_valid,
    input  logic [31:0]           nonce_in,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic [DEPTH_LOG2-1:0] rptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  overflow_q;
    logic [7:0]            drop_count_q;

    state_t                state_q;
    logic [31:0]           frame_q;
    logic [2:0]            idx_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic        fifo_empty;
    logic        fifo_full;
    logic        xfer;
    logic        last_xfer;
    logic        pop;
    logic        push;
    logic        drop;
    logic [31:0] head;

    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_W'(DEPTH));
        xfer       = (state_q == SEND) && tx_ready;
        last_xfer  = xfer && (idx_q == 3'd4);
        // Head is taken either to start a frame from IDLE or to chain the
        // next frame directly off the final byte transfer.
        pop        = !fifo_empty && ((state_q == IDLE) || last_xfer);
        // A same-cycle pop frees a slot, so a full queue can still accept.
        push       = nonce_valid && (!fifo_full || pop);
        drop       = nonce_valid && fifo_full && !pop;
        head       = mem_q[rptr_q];
    end

    // Payload byte sent at frame position i (1..4), MSB first.
    function automatic logic [7:0] nonce_byte(input logic [31:0] w,
                                              input logic [2:0]  i);
        logic [7:0] b;
        case (i)
            3'd1:    b = w[31:24];
            3'd2:    b = w[23:16];
            3'd3:    b = w[15:8];
            3'd4:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Queue storage (no reset needed; validity tracked by pointers/level)
    // ------------------------------------------------------------------
    always_ff @(posedge hash_clk) begin
        if (!reset && push) begin
            mem_q[wptr_q] <= nonce_in;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, level and drop bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_q <= drop_count_q + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered tx outputs
    // ------------------------------------------------------------------
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        frame_q    <= head;
                        idx_q      <= '0;
                        tx_data_q  <= HEADER;
                        tx_valid_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (idx_q == 3'd4) begin
                            if (pop) begin
                                frame_q   <= head;
                                idx_q     <= '0;
                                tx_data_q <= HEADER;
                            end else begin
                                idx_q      <= '0;
                                tx_data_q  <= 8'h00;
                                tx_valid_q <= 1'b0;
                                state_q    <= IDLE;
                            end
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            tx_data_q <= nonce_byte(frame_q, idx_q + 3'd1);
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// ---------------------------------------------------------------------------
// tb_golden_nonce_reporter
//
// Drives directed scenarios and a randomized run into golden_nonce_reporter
// and compares every cycle against a queue-based reference: a queue of
// pending nonces plus a queue of bytes left in the frame in flight.
// ---------------------------------------------------------------------------
module tb_golden_nonce_reporter;

    localparam int unsigned DLOG2 = 2;
    localparam int unsigned DEPTH = 1 << DLOG2;
    localparam logic [7:0]  HDR   = 8'hA5;

    logic             hash_clk;
    logic             reset;
    logic             nonce_valid;
    logic [31:0]      nonce_in;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [DLOG2:0]   fifo_level;
    logic             overflow;
    logic [7:0]       drop_count;

    golden_nonce_reporter #(
        .DEPTH_LOG2(DLOG2),
        .HEADER    (HDR)
    ) dut (
        .hash_clk   (hash_clk),
        .reset      (reset),
        .nonce_valid(nonce_valid),
        .nonce_in   (nonce_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference state
    logic [31:0] mq[$];       // queued nonces
    logic [7:0]  mf[$];       // bytes still to send in current frame
    int unsigned mdrop = 0;
    bit          movf  = 1'b0;

    logic [7:0]  sent[$];     // bytes actually transferred by the DUT

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input logic v, input logic [31:0] n,
                              input logic rdy, input logic rst);
        bit sending, done, popping;
        logic [31:0] h;
        if (rst) begin
            mq.delete();
            mf.delete();
            mdrop = 0;
            movf  = 1'b0;
            return;
        end
        sending = (mf.size() > 0);
        done    = sending && rdy && (mf.size() == 1);
        popping = (mq.size() > 0) && (!sending || done);
        if (sending && rdy) void'(mf.pop_front());
        if (v) begin
            if (mq.size() < DEPTH || popping) begin
                if (popping) begin
                    h = mq.pop_front();
                    mf = '{HDR, h[31:24], h[23:16], h[15:8], h[7:0]};
                    popping = 1'b0;
                end
                mq.push_back(n);
            end else begin
                movf = 1'b1;
                if (mdrop < 255) mdrop++;
            end
        end
        if (popping) begin
            h = mq.pop_front();
            mf = '{HDR, h[31:24], h[23:16], h[15:8], h[7:0]};
        end
    endtask

    // Apply inputs for one cycle, advance the model, compare outputs.
    task automatic step(input logic v, input logic [31:0] n,
                        input logic rdy, input logic rst);
        nonce_valid = v;
        nonce_in    = n;
        tx_ready    = rdy;
        reset       = rst;
        #1;
        if (!rst && tx_valid && rdy) sent.push_back(tx_data);
        @(posedge hash_clk);
        model_edge(v, n, rdy, rst);
        #1;
        check_eq("tx_valid", 32'(tx_valid), 32'(mf.size() > 0));
        if (mf.size() > 0) check_eq("tx_data", 32'(tx_data), 32'(mf[0]));
        if (rst) check_eq("reset_tx_data", 32'(tx_data), 32'h0);
        check_eq("fifo_level", 32'(fifo_level), mq.size());
        check_eq("overflow", 32'(overflow), 32'(movf));
        check_eq("drop_count", 32'(drop_count), mdrop);
    endtask

    task automatic idle_cycles(input int unsigned k, input logic rdy);
        for (int unsigned i = 0; i < k; i++) step(1'b0, 32'h0, rdy, 1'b0);
    endtask

    task automatic check_sent(input string tag, input logic [7:0] exp[$]);
        check_eq({tag, "_len"}, sent.size(), exp.size());
        for (int i = 0; i < exp.size() && i < sent.size(); i++)
            check_eq(tag, 32'(sent[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [7:0] exp[$];

        nonce_valid = 1'b0;
        nonce_in    = '0;
        tx_ready    = 1'b0;
        reset       = 1'b1;

        // Reset, with a stray pulse that must be ignored
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);

        // Single nonce, tx_ready high: 2-cycle latency, 5 consecutive bytes
        sent.delete();
        step(1'b1, 32'h1D2C3B4A, 1'b1, 1'b0);
        check_eq("lat_pulse_edge", 32'(tx_valid), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("lat_hdr_valid", 32'(tx_valid), 32'h1);
        check_eq("lat_hdr_data", 32'(tx_data), 32'hA5);
        idle_cycles(6, 1'b1);
        exp = '{8'hA5, 8'h1D, 8'h2C, 8'h3B, 8'h4A};
        check_sent("single", exp);
        check_eq("single_idle", 32'(tx_valid), 32'h0);

        // Backpressure: header held for 10 cycles, then frame completes
        sent.delete();
        step(1'b1, 32'h11223344, 1'b0, 1'b0);
        idle_cycles(11, 1'b0);
        check_eq("bp_hold_data", 32'(tx_data), 32'hA5);
        idle_cycles(7, 1'b1);
        exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
        check_sent("backpressure", exp);

        // Overflow: six pulses against a stalled transmitter
        step(1'b0, 32'h0, 1'b0, 1'b1);
        sent.delete();
        for (int unsigned k = 1; k <= 6; k++) step(1'b1, 32'(k), 1'b0, 1'b0);
        check_eq("ovf_level", 32'(fifo_level), 32'd4);
        check_eq("ovf_drop", 32'(drop_count), 32'd1);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        idle_cycles(30, 1'b1);
        exp.delete();
        for (int unsigned k = 1; k <= 5; k++) begin
            exp.push_back(HDR); exp.push_back(8'h00);
            exp.push_back(8'h00); exp.push_back(8'h00);
            exp.push_back(8'(k));
        end
        check_sent("b2b_frames", exp);

        // Full queue with a pulse on the byte-4 transfer cycle: accepted
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int unsigned k = 1; k <= 5; k++) step(1'b1, 32'(k), 1'b0, 1'b0);
        idle_cycles(4, 1'b1);
        step(1'b1, 32'h00000077, 1'b1, 1'b0);
        check_eq("edge_push_level", 32'(fifo_level), 32'd4);
        check_eq("edge_push_drop", 32'(drop_count), 32'd0);
        idle_cycles(30, 1'b1);

        // Reset mid-frame (on byte 2) with 3 queued
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int unsigned k = 1; k <= 4; k++) step(1'b1, 32'(k), 1'b0, 1'b0);
        idle_cycles(2, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("rst_mid_valid", 32'(tx_valid), 32'h0);
        check_eq("rst_mid_level", 32'(fifo_level), 32'h0);
        check_eq("rst_mid_ovf", 32'(overflow), 32'h0);
        sent.delete();
        step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        idle_cycles(8, 1'b1);
        exp = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_sent("after_reset", exp);

        // Saturating drop counter
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int unsigned k = 0; k < 305; k++) step(1'b1, $urandom, 1'b0, 1'b0);
        check_eq("sat_drop", 32'(drop_count), 32'hFF);
        check_eq("sat_ovf", 32'(overflow), 32'h1);

        // Randomized run against the reference
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int unsigned k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) < 30), $urandom,
                 ($urandom_range(0, 99) < 65),
                 ($urandom_range(0, 599) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
